// File: rtl/rr_writeback_axi.sv
`default_nettype none
// ============================================================================
// Module   : rr_writeback_axi
// Purpose  : Bit-packs variable-width record log units into AXI beats and
//            writes them into a host circular buffer, one beat at a time.
// Revision : 1.0 - initial release
// ============================================================================
module rr_writeback_axi #(
    parameter int WIDTH            = 100,
    parameter int AXI_WIDTH        = 512,
    parameter int OFFSET_WIDTH     = 16,
    parameter int AXI_ADDR_WIDTH   = 64,
    parameter int LOGB_CHANNEL_CNT = 1,
    parameter int LOGE_CHANNEL_CNT = 1,
    parameter int CHANNEL_CNT      = 2,
    parameter logic [CHANNEL_CNT*32-1:0] CHANNEL_WIDTHS = {32'd48, 32'd50}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                cfg_max_payload,
    input  logic                      record_din_valid,
    output logic                      record_din_ready,
    input  logic [WIDTH-1:0]          record_din,
    input  logic [OFFSET_WIDTH-1:0]   record_din_width,
    input  logic                      record_finish,
    output logic [AXI_ADDR_WIDTH-1:0] axi_out_awaddr,
    output logic [7:0]                axi_out_awlen,
    output logic [2:0]                axi_out_awsize,
    output logic                      axi_out_awvalid,
    input  logic                      axi_out_awready,
    output logic [AXI_WIDTH-1:0]      axi_out_wdata,
    output logic [AXI_WIDTH/8-1:0]    axi_out_wstrb,
    output logic                      axi_out_wlast,
    output logic                      axi_out_wvalid,
    input  logic                      axi_out_wready,
    input  logic [1:0]                axi_out_bresp,
    input  logic                      axi_out_bvalid,
    output logic                      axi_out_bready,
    output logic                      axi_out_arvalid,
    output logic                      axi_out_rready,
    input  logic [63:0]               write_buf_addr,
    input  logic [31:0]               write_buf_size,
    input  logic                      write_buf_update,
    input  logic [63:0]               read_buf_addr,
    input  logic [31:0]               read_buf_size,
    input  logic                      read_buf_update,
    output logic                      write_interrupt,
    output logic                      read_interrupt
);

    localparam int ACC_W      = AXI_WIDTH - 1 + WIDTH;
    localparam int FILL_W     = $clog2(AXI_WIDTH + WIDTH);
    localparam int BEAT_BYTES = AXI_WIDTH / 8;

    function automatic int channel_sum();
        int s;
        s = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
        for (int i = 0; i < CHANNEL_CNT; i++) s += int'(CHANNEL_WIDTHS[i*32 +: 32]);
        return s;
    endfunction

    if (channel_sum() != WIDTH) begin : g_width_check
        $error("rr_writeback_axi: WIDTH does not match the channel layout");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    state_t                    r_state, w_state_next;
    logic [63:0]               r_base;
    logic [31:0]               r_size, r_offset, w_next_off;
    logic [ACC_W-1:0]          r_acc, w_append;
    logic [FILL_W-1:0]         r_fill, w_len;
    logic [AXI_WIDTH-1:0]      r_beat;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [WIDTH-1:0]          w_mask;
    logic r_flushing, r_cfg_dirty, r_aw_done, r_w_done, r_irq;
    logic w_full, w_partial, w_load, w_accept, w_aw_hs, w_w_hs, w_b_done, w_wrap, w_flush_done;
    logic unused_inputs;

    assign unused_inputs = ^{cfg_max_payload, axi_out_bresp, read_buf_addr, read_buf_size, read_buf_update};

    always_comb begin
        w_len = FILL_W'(record_din_width);
        if (record_din_width > OFFSET_WIDTH'(WIDTH)) w_len = FILL_W'(WIDTH);
    end

    // Shifting all-ones by len >= WIDTH yields zero, so the mask saturates to all ones.
    assign w_mask   = ~({WIDTH{1'b1}} << w_len);
    assign w_append = ACC_W'(record_din & w_mask) << r_fill;

    assign record_din_ready = (r_size != 32'd0) && !r_flushing && (r_fill < FILL_W'(AXI_WIDTH));
    assign w_accept     = record_din_valid && record_din_ready;
    assign w_full       = r_fill >= FILL_W'(AXI_WIDTH);
    assign w_partial    = r_flushing && (r_fill != '0) && !w_full;
    assign w_load       = (r_state == S_IDLE) && (w_full || w_partial);
    assign w_aw_hs      = axi_out_awvalid && axi_out_awready;
    assign w_w_hs       = axi_out_wvalid && axi_out_wready;
    assign w_b_done     = (r_state == S_RESP) && axi_out_bvalid;
    assign w_next_off   = r_offset + 32'(BEAT_BYTES);
    assign w_wrap       = w_b_done && !r_cfg_dirty && (w_next_off >= r_size);
    assign w_flush_done = r_flushing && (r_fill == '0) && ((r_state == S_IDLE) || w_b_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_load) w_state_next = S_ADDR_DATA;
            S_ADDR_DATA: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = S_RESP;
            S_RESP:      if (axi_out_bvalid) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    assign axi_out_awvalid = (r_state == S_ADDR_DATA) && !r_aw_done;
    assign axi_out_wvalid  = (r_state == S_ADDR_DATA) && !r_w_done;
    assign axi_out_bready  = (r_state == S_RESP);
    assign axi_out_awaddr  = r_awaddr;
    assign axi_out_awlen   = 8'd0;
    assign axi_out_awsize  = 3'($clog2(BEAT_BYTES));
    assign axi_out_wdata   = r_beat;
    assign axi_out_wstrb   = '1;
    assign axi_out_wlast   = 1'b1;
    assign axi_out_arvalid = 1'b0;
    assign axi_out_rready  = 1'b1;
    assign write_interrupt = r_irq;
    assign read_interrupt  = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_size      <= '0;
            r_offset    <= '0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_beat      <= '0;
            r_awaddr    <= '0;
            r_flushing  <= 1'b0;
            r_cfg_dirty <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (write_buf_update) begin
                r_base <= write_buf_addr;
                r_size <= write_buf_size;
            end
            // A reconfiguration under an in-flight beat must not advance the fresh offset.
            if (write_buf_update)
                r_offset <= '0;
            else if (w_b_done && !r_cfg_dirty)
                r_offset <= w_wrap ? 32'd0 : w_next_off;
            if (write_buf_update && ((r_state != S_IDLE) || w_load))
                r_cfg_dirty <= 1'b1;
            else if (w_load)
                r_cfg_dirty <= 1'b0;

            if (w_accept) begin
                r_acc  <= r_acc | w_append;
                r_fill <= r_fill + w_len;
            end else if (w_load) begin
                r_beat   <= r_acc[AXI_WIDTH-1:0];
                r_awaddr <= AXI_ADDR_WIDTH'(r_base + {32'd0, r_offset});
                if (w_full) begin
                    r_acc  <= r_acc >> AXI_WIDTH;
                    r_fill <= r_fill - FILL_W'(AXI_WIDTH);
                end else begin
                    r_acc  <= '0;
                    r_fill <= '0;
                end
            end

            if (r_state == S_ADDR_DATA) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (record_finish)     r_flushing <= 1'b1;
            else if (w_flush_done) r_flushing <= 1'b0;
            r_irq <= w_wrap || w_flush_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_writeback_axi.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_writeback_axi
// Purpose  : Directed self-checking bench for rr_writeback_axi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_writeback_axi;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   cfg_max_payload;
    logic         record_din_valid, record_din_ready, record_finish;
    logic [99:0]  record_din;
    logic [15:0]  record_din_width;
    logic [63:0]  axi_out_awaddr;
    logic [7:0]   axi_out_awlen;
    logic [2:0]   axi_out_awsize;
    logic         axi_out_awvalid, axi_out_awready, axi_out_wlast, axi_out_wvalid, axi_out_wready;
    logic [511:0] axi_out_wdata;
    logic [63:0]  axi_out_wstrb;
    logic [1:0]   axi_out_bresp;
    logic         axi_out_bvalid, axi_out_bready, axi_out_arvalid, axi_out_rready;
    logic [63:0]  write_buf_addr, read_buf_addr;
    logic [31:0]  write_buf_size, read_buf_size;
    logic         write_buf_update, read_buf_update, write_interrupt, read_interrupt;

    rr_writeback_axi #(
        .WIDTH(100), .AXI_WIDTH(512), .OFFSET_WIDTH(16), .AXI_ADDR_WIDTH(64),
        .LOGB_CHANNEL_CNT(1), .LOGE_CHANNEL_CNT(1), .CHANNEL_CNT(2),
        .CHANNEL_WIDTHS({32'd48, 32'd50})
    ) dut (
        .clk(clk), .rst(rst), .cfg_max_payload(cfg_max_payload),
        .record_din_valid(record_din_valid), .record_din_ready(record_din_ready),
        .record_din(record_din), .record_din_width(record_din_width), .record_finish(record_finish),
        .axi_out_awaddr(axi_out_awaddr), .axi_out_awlen(axi_out_awlen), .axi_out_awsize(axi_out_awsize),
        .axi_out_awvalid(axi_out_awvalid), .axi_out_awready(axi_out_awready),
        .axi_out_wdata(axi_out_wdata), .axi_out_wstrb(axi_out_wstrb), .axi_out_wlast(axi_out_wlast),
        .axi_out_wvalid(axi_out_wvalid), .axi_out_wready(axi_out_wready),
        .axi_out_bresp(axi_out_bresp), .axi_out_bvalid(axi_out_bvalid), .axi_out_bready(axi_out_bready),
        .axi_out_arvalid(axi_out_arvalid), .axi_out_rready(axi_out_rready),
        .write_buf_addr(write_buf_addr), .write_buf_size(write_buf_size), .write_buf_update(write_buf_update),
        .read_buf_addr(read_buf_addr), .read_buf_size(read_buf_size), .read_buf_update(read_buf_update),
        .write_interrupt(write_interrupt), .read_interrupt(read_interrupt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int stall_cnt = 0, aw_delay = 0, aw_wait = 0, aw_stall = 0, proto_viol = 0, b_cnt = 0;
    logic aw_got = 1'b0, w_got = 1'b0;
    logic [63:0]  beat_addr[$];
    logic [511:0] beat_data[$];
    int           irq_log[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [99:0] nib(input int n);
        return {25{4'(n)}};
    endfunction

    // Slave: awready after aw_delay cycles, wready immediate, B one cycle after both.
    initial begin
        axi_out_awready = 1'b0; axi_out_wready = 1'b0; axi_out_bvalid = 1'b0; axi_out_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi_out_awready = 1'b0; axi_out_wready = 1'b0; axi_out_bvalid = 1'b0;
                aw_got = 1'b0; w_got = 1'b0; aw_wait = aw_delay;
            end else begin
                if (axi_out_awvalid && aw_got) proto_viol++;
                if (axi_out_wvalid && w_got)   proto_viol++;
                if (axi_out_bvalid) begin
                    axi_out_bvalid = 1'b0;
                    b_cnt++;
                end else if (aw_got && w_got && axi_out_bready) begin
                    axi_out_bvalid = 1'b1;
                    aw_got = 1'b0; w_got = 1'b0; aw_wait = aw_delay;
                end
                if (write_interrupt) irq_log.push_back(b_cnt);
                axi_out_awready = 1'b0;
                if (axi_out_awvalid && !aw_got) begin
                    if (aw_wait > 0) begin
                        aw_wait--; aw_stall++;
                    end else begin
                        axi_out_awready = 1'b1; aw_got = 1'b1;
                        beat_addr.push_back(axi_out_awaddr);
                    end
                end
                axi_out_wready = 1'b0;
                if (axi_out_wvalid && !w_got) begin
                    axi_out_wready = 1'b1; w_got = 1'b1;
                    beat_data.push_back(axi_out_wdata);
                end
            end
        end
    end

    task automatic clear_logs();
        beat_addr.delete(); beat_data.delete(); irq_log.delete();
        b_cnt = 0; aw_stall = 0; proto_viol = 0;
    endtask

    task automatic cfg(input logic [63:0] addr, input logic [31:0] size);
        write_buf_addr = addr; write_buf_size = size; write_buf_update = 1'b1;
        @(negedge clk);
        write_buf_update = 1'b0;
    endtask

    task automatic send(input logic [99:0] d, input logic [15:0] w);
        int t = 0;
        record_din = d; record_din_width = w; record_din_valid = 1'b1;
        while (!record_din_ready && t < 200) begin
            @(negedge clk); t++; stall_cnt++;
        end
        check("send_ready", record_din_ready, 1'b1);
        @(negedge clk);
        record_din_valid = 1'b0;
    endtask

    task automatic finish_pulse();
        record_finish = 1'b1;
        @(negedge clk);
        record_finish = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_addr.size() < n && t < 2000) begin @(negedge clk); t++; end
        check("beat_count", beat_addr.size(), n);
    endtask

    task automatic wait_b(input int n);
        int t = 0;
        while (b_cnt < n && t < 2000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check("b_count", b_cnt, n);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [99:0]  r6;
        logic [511:0] exp;
        int t;
        rst = 1'b1; cfg_max_payload = 2'b00; record_din_valid = 1'b0; record_din = '0;
        record_din_width = '0; record_finish = 1'b0; write_buf_addr = '0; write_buf_size = '0;
        write_buf_update = 1'b0; read_buf_addr = '0; read_buf_size = '0; read_buf_update = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", record_din_ready, 1'b0);
        check("rst_awvalid", axi_out_awvalid, 1'b0);
        check("rst_wvalid", axi_out_wvalid, 1'b0);
        check("rst_bready", axi_out_bready, 1'b0);
        check("rst_irqs", {write_interrupt, read_interrupt, axi_out_arvalid, axi_out_rready}, 4'b0001);
        rst = 1'b0;

        // Unconfigured, then configured with size 0: never ready
        record_din_valid = 1'b1; record_din = nib(1); record_din_width = 16'd100;
        repeat (3) @(negedge clk);
        check("ready_unconfigured", record_din_ready, 1'b0);
        cfg(64'h5000, 32'h0);
        @(negedge clk);
        check("ready_size0", record_din_ready, 1'b0);
        record_din_valid = 1'b0;

        // Ten records, then sixteen more -> five beats through a wrapping buffer
        clear_logs();
        cfg(64'h1000, 32'h100);
        stall_cnt = 0;
        for (int k = 0; k < 10; k++) send(nib(k % 15 + 1), 16'd100);
        check("ready_stall_cycles", stall_cnt, 1);
        for (int k = 10; k < 26; k++) send(nib(k % 15 + 1), 16'd100);
        wait_beats(5);
        wait_b(5);
        r6  = nib(6);
        exp = {r6[11:0], nib(5), nib(4), nib(3), nib(2), nib(1)};
        check("beat0_data", beat_data[0], exp);
        check("beat0_addr", beat_addr[0], 64'h1000);
        check("beat1_addr", beat_addr[1], 64'h1040);
        check("beat2_addr", beat_addr[2], 64'h1080);
        check("beat3_addr", beat_addr[3], 64'h10C0);
        check("beat4_addr", beat_addr[4], 64'h1000);
        check("wrap_irq_count", irq_log.size(), 1);
        check("wrap_irq_after_b", irq_log[0], 4);

        // Flush the 40 leftover bits (upper bits of record 25)
        repeat (3) @(negedge clk);
        finish_pulse();
        wait_beats(6);
        wait_b(6);
        check("flush40_addr", beat_addr[5], 64'h1040);
        check("flush40_data", beat_data[5], 512'h00BB_BBBB_BBBB);
        check("flush40_irq_count", irq_log.size(), 2);
        check("flush40_irq_after_b", irq_log[1], 6);

        // awready stalled 5 cycles per beat, wready immediate
        clear_logs();
        aw_delay = 5; aw_wait = 5;
        cfg(64'h3000, 32'h1000);
        for (int k = 0; k < 6; k++) send(nib(k + 1), 16'd100);
        check("lat_n1_awvalid", axi_out_awvalid, 1'b0);
        @(negedge clk);
        check("lat_n2_awvalid", axi_out_awvalid, 1'b1);
        check("aw_consts", {axi_out_awlen, axi_out_awsize, axi_out_wlast}, {8'd0, 3'd6, 1'b1});
        check("wstrb", axi_out_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int k = 6; k < 11; k++) send(nib(k + 1), 16'd100);
        wait_beats(2);
        wait_b(2);
        check("stall_beat0_addr", beat_addr[0], 64'h3000);
        check("stall_beat1_addr", beat_addr[1], 64'h3040);
        check("aw_stall_cycles", aw_stall, 10);
        check("protocol_violations", proto_viol, 0);

        // Reset while stuck in ADDR_DATA
        aw_delay = 1000; aw_wait = 1000;
        cfg(64'h4000, 32'h100);
        for (int k = 0; k < 6; k++) send(nib(k + 1), 16'd100);
        t = 0;
        while (!axi_out_awvalid && t < 50) begin @(negedge clk); t++; end
        check("awvalid_before_reset", axi_out_awvalid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_valids", {axi_out_awvalid, axi_out_wvalid}, 2'b00);
        check("midreset_ready", record_din_ready, 1'b0);
        aw_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postreset_ready", record_din_ready, 1'b0);

        // Masking, zero-length, clamp, then flush a 240-bit partial beat
        clear_logs();
        cfg(64'h2000, 32'h100);
        send(nib(1), 16'd100);
        send({100{1'b1}}, 16'd0);
        send({100{1'b1}}, 16'd40);
        send(nib(3), 16'd200);
        finish_pulse();
        check("ready_while_flushing", record_din_ready, 1'b0);
        wait_beats(1);
        wait_b(1);
        exp = {272'd0, nib(3), 40'hFF_FFFF_FFFF, nib(1)};
        check("flush240_addr", beat_addr[0], 64'h2000);
        check("flush240_data", beat_data[0], exp);
        check("flush240_irq_count", irq_log.size(), 1);
        check("flush240_irq_after_b", irq_log[0], 1);
        check("ready_after_flush", record_din_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
